// File: rtl/mac_inverse_divider_pkg.sv
// Shared types and constants for the MAC inverse divider: FSM state encoding,
// default operand widths and the signed quotient limits.
package mac_inverse_divider_pkg;

    localparam int DEF_DIVIDEND_W = 32;
    localparam int DEF_DIVISOR_W  = 16;

    localparam logic signed [DEF_DIVISOR_W-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [DEF_DIVISOR_W-1:0] Q_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/mac_inverse_divider_sat_signed.sv
// Signed saturator: clamps a wide two's-complement value into OUT_W bits and
// flags when clamping happened. Also usable on the MAC output path.
module sat_signed #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  i_value,
    output logic [OUT_W-1:0] o_value,
    output logic             o_sat
);

    logic [IN_W-OUT_W:0] w_upper;
    logic                w_fits;

    // The value fits when every bit above the output sign bit copies the sign.
    assign w_upper = i_value[IN_W-1:OUT_W-1];
    assign w_fits  = (&w_upper) | (~|w_upper);
    assign o_sat   = ~w_fits;

    always_comb begin
        o_value = i_value[OUT_W-1:0];
        if (!w_fits) begin
            o_value = i_value[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                      : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mac_inverse_divider.sv
// Sequential restoring signed divider (one quotient bit per clock) that undoes
// the 16x16 MAC multiply, producing a saturated quotient and signed remainder.
module mac_inverse_divider
    import mac_inverse_divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIVIDEND_W-1:0] dividend,
    input  logic signed [DIVISOR_W-1:0]  divisor,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DIVISOR_W-1:0]  quotient,
    output logic signed [DIVISOR_W-1:0]  remainder,
    output logic                         ovf,
    output logic                         div_zero
);

    localparam int              CNT_W    = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

    state_t r_state;
    state_t w_nextState;

    logic signed [DIVIDEND_W-1:0] r_dd;
    logic signed [DIVISOR_W-1:0]  r_dv;
    logic [DIVIDEND_W-1:0]        r_quo;
    logic [DIVISOR_W-1:0]         r_rem;
    logic [DIVISOR_W:0]           r_dvMag;
    logic [CNT_W-1:0]             r_count;
    logic                         r_negQ;
    logic                         r_negR;
    logic                         r_divZero;

    logic signed [DIVISOR_W-1:0]  r_quotient;
    logic signed [DIVISOR_W-1:0]  r_remainder;
    logic                         r_ovf;
    logic                         r_divZeroOut;

    logic [DIVIDEND_W-1:0]        w_ddMag;
    logic [DIVISOR_W:0]           w_dvExt;
    logic [DIVISOR_W:0]           w_dvMag;
    logic [DIVISOR_W:0]           w_shift;
    logic                         w_fits;
    logic [DIVISOR_W-1:0]         w_diff;
    logic [DIVIDEND_W:0]          w_qSigned;
    logic [DIVISOR_W-1:0]         w_qSat;
    logic                         w_qOvf;
    logic [DIVISOR_W-1:0]         w_remSigned;

    // Read as unsigned, the negated dividend holds 2^31 exactly.
    assign w_ddMag = r_dd[DIVIDEND_W-1] ? DIVIDEND_W'(-r_dd) : DIVIDEND_W'(r_dd);
    assign w_dvExt = {r_dv[DIVISOR_W-1], r_dv};
    assign w_dvMag = w_dvExt[DIVISOR_W] ? -w_dvExt : w_dvExt;

    assign w_shift = {r_rem, r_quo[DIVIDEND_W-1]};
    assign w_fits  = (w_shift >= r_dvMag);
    assign w_diff  = w_shift[DIVISOR_W-1:0] - r_dvMag[DIVISOR_W-1:0];

    assign w_qSigned   = r_negQ ? -{1'b0, r_quo} : {1'b0, r_quo};
    assign w_remSigned = r_negR ? -r_rem : r_rem;

    sat_signed #(
        .IN_W  (DIVIDEND_W + 1),
        .OUT_W (DIVISOR_W)
    ) u_sat (
        .i_value (w_qSigned),
        .o_value (w_qSat),
        .o_sat   (w_qOvf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_nextState = PREP;
            PREP:    w_nextState = DIV;
            DIV:     if (r_count == '0) w_nextState = FIX;
            FIX:     w_nextState = DONE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dd         <= '0;
            r_dv         <= '0;
            r_quo        <= '0;
            r_rem        <= '0;
            r_dvMag      <= '0;
            r_count      <= '0;
            r_negQ       <= 1'b0;
            r_negR       <= 1'b0;
            r_divZero    <= 1'b0;
            r_quotient   <= '0;
            r_remainder  <= '0;
            r_ovf        <= 1'b0;
            r_divZeroOut <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dd <= dividend;
                        r_dv <= divisor;
                    end
                end
                PREP: begin
                    r_quo     <= w_ddMag;
                    r_rem     <= '0;
                    r_dvMag   <= w_dvMag;
                    r_negQ    <= r_dd[DIVIDEND_W-1] ^ r_dv[DIVISOR_W-1];
                    r_negR    <= r_dd[DIVIDEND_W-1];
                    r_divZero <= (r_dv == '0);
                    r_count   <= CNT_LAST;
                end
                DIV: begin
                    r_quo   <= {r_quo[DIVIDEND_W-2:0], w_fits};
                    r_rem   <= w_fits ? w_diff : w_shift[DIVISOR_W-1:0];
                    r_count <= r_count - 1'b1;
                end
                FIX: begin
                    // A zero divisor saturates toward the dividend's sign with no overflow.
                    if (r_divZero) begin
                        r_quotient  <= r_negR ? {1'b1, {(DIVISOR_W-1){1'b0}}}
                                              : {1'b0, {(DIVISOR_W-1){1'b1}}};
                        r_remainder <= '0;
                        r_ovf       <= 1'b0;
                    end else begin
                        r_quotient  <= w_qSat;
                        r_remainder <= w_remSigned;
                        r_ovf       <= w_qOvf;
                    end
                    r_divZeroOut <= r_divZero;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign ovf       = r_ovf;
    assign div_zero  = r_divZeroOut;

endmodule

// File: tb/tb_mac_inverse_divider.sv
// Scoreboard bench for mac_inverse_divider: directed spec cases, handshake and
// reset scenarios, then randomized operands against an integer-division model.
module tb_mac_inverse_divider;
    import mac_inverse_divider_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] dividend = '0;
    logic signed [15:0] divisor = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] quotient;
    logic signed [15:0] remainder;
    logic               ovf;
    logic               div_zero;

    typedef struct {
        longint q;
        longint r;
        bit     ovf;
        bit     dz;
        int     acc;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount = 0;
    int   cycleCount = 0;
    bit   readyRandom = 1'b0;
    bit   prevValid = 1'b0;

    mac_inverse_divider dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .div_zero  (div_zero)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Cycle counter used to measure accept-to-valid latency.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Hard stop if something stalls far beyond the expected run length.
    always @(posedge clk) begin
        if (cycleCount > 99000) begin
            $display("[TB] FAIL watchdog: cycles %0d exceeded limit 99000", cycleCount);
            $fatal(1, "[TB] watchdog expired");
        end
    end

    // Consumer backpressure: random out_ready while the random phase runs.
    always @(posedge clk) begin
        #1;
        if (readyRandom) out_ready = ($urandom_range(9) < 7);
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Reference: plain truncating integer division, then saturation to 16 bits.
    function automatic exp_t model(input longint dd, input longint dv);
        exp_t e;
        e.acc = 0;
        e.ovf = 1'b0;
        if (dv == 0) begin
            e.q  = (dd >= 0) ? longint'(Q_MAX) : longint'(Q_MIN);
            e.r  = 0;
            e.dz = 1'b1;
        end else begin
            longint q;
            q    = dd / dv;
            e.r  = dd % dv;
            e.dz = 1'b0;
            if (q > longint'(Q_MAX)) begin
                q     = longint'(Q_MAX);
                e.ovf = 1'b1;
            end else if (q < longint'(Q_MIN)) begin
                q     = longint'(Q_MIN);
                e.ovf = 1'b1;
            end
            e.q = q;
        end
        return e;
    endfunction

    // Issue one operation (caller sits at posedge+1) and push its expected result.
    task automatic applyStimulus(input longint dd, input longint dv);
        int   n = 0;
        exp_t e;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 0, 1);
            return;
        end
        dividend = dd[31:0];
        divisor  = dv[15:0];
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e     = model(dd, dv);
        e.acc = cycleCount;
        expQ.push_back(e);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain", expQ.size(), 0);
        expQ.delete();
    endtask

    function automatic longint pickDd();
        case ($urandom_range(7))
            0:       return 64'shFFFF_FFFF_8000_0000;
            1:       return 64'sd2147483647;
            2:       return 0;
            3:       return longint'(shortint'($urandom));
            4:       return -32768;
            default: return longint'(int'($urandom));
        endcase
    endfunction

    function automatic longint pickDv();
        case ($urandom_range(7))
            0:       return -32768;
            1:       return 0;
            2:       return 1;
            3:       return -1;
            4:       return longint'(byte'($urandom));
            default: return longint'(shortint'($urandom));
        endcase
    endfunction

    // Monitor: latency on each rising out_valid, full compare on each handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && !prevValid && expQ.size() > 0)
                checkOutput("latency", longint'(cycleCount - expQ[0].acc), 34);
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("quotient", longint'(quotient), e.q);
                    checkOutput("remainder", longint'(remainder), e.r);
                    checkOutput("ovf", longint'(ovf), longint'(e.ovf));
                    checkOutput("div_zero", longint'(div_zero), longint'(e.dz));
                end
            end
        end
        prevValid = out_valid;
    end

    longint dirDd[10] = '{2000000, -7, 7, -7, 3, 1000000, 64'shFFFF_FFFF_8000_0000, -32768, 5, -5};
    longint dirDv[10] = '{-1000, 2, -2, -2, 5, 1, -1, 1, 0, 0};

    initial begin
        exp_t e;
        int   n;

        $display("[TB] reset phase");
        repeat (3) @(negedge clk);
        checkOutput("reset_out_valid", longint'(out_valid), 0);
        checkOutput("reset_in_ready", longint'(in_ready), 1);
        checkOutput("reset_quotient", longint'(quotient), 0);
        checkOutput("reset_remainder", longint'(remainder), 0);
        checkOutput("reset_ovf", longint'(ovf), 0);
        checkOutput("reset_div_zero", longint'(div_zero), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        $display("[TB] directed cases");
        for (int i = 0; i < 10; i++) applyStimulus(dirDd[i], dirDv[i]);
        waitDrain();

        $display("[TB] stalled consumer with busy in_valid");
        out_ready = 1'b0;
        applyStimulus(123456789, -321);
        e = model(123456789, -321);
        n = 0;
        while (!out_valid && n < 60) begin
            in_valid = 1'b1;
            dividend = int'($urandom);
            divisor  = shortint'($urandom);
            @(posedge clk); #1;
            n++;
        end
        checkOutput("stall_reached_valid", longint'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_quotient", longint'(quotient), e.q);
            checkOutput("stall_remainder", longint'(remainder), e.r);
            checkOutput("stall_out_valid", longint'(out_valid), 1);
            checkOutput("stall_in_ready", longint'(in_ready), 0);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain();

        $display("[TB] reset during iteration");
        applyStimulus(999999, 7);
        repeat (11) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", longint'(out_valid), 0);
        checkOutput("midreset_in_ready", longint'(in_ready), 1);
        checkOutput("midreset_quotient", longint'(quotient), 0);
        expQ.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("no_stale_out_valid", longint'(out_valid), 0);
        applyStimulus(40000, 200);
        waitDrain();

        $display("[TB] randomized operands");
        readyRandom = 1'b1;
        for (int i = 0; i < 1500; i++) applyStimulus(pickDd(), pickDv());
        readyRandom = 1'b0;
        out_ready   = 1'b1;
        waitDrain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
